// File: rtl/post_filter_pkg.sv
// Shared constants for the post-detection filter scheduler: state encoding,
// default geometry/latency and a counter-width helper.
package post_filter_pkg;

  localparam int unsigned IMG_W_DEF    = 640;
  localparam int unsigned IMG_H_DEF    = 480;
  localparam int unsigned ADDR_W_DEF   = 19;
  localparam int unsigned FILT_LAT_DEF = 3;

  localparam int unsigned STATE_W = 2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // ceil(log2(n)), never narrower than one bit so single-value counters still exist
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Valid-tag shift register that tracks which filter pipeline stages hold a real pixel.
module valid_delay_line #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  input  logic din,
  input  logic clear,
  output logic dout
);

  logic [DEPTH-1:0] stages;

  // clear wins over shift so an abort or new frame never leaks stale tags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stages <= '0;
    end else if (clear) begin
      stages <= '0;
    end else if (shift_en) begin
      stages <= (stages << 1) | DEPTH'(din);
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/post_filter_scheduler.sv
// Reads a buffered frame row-major into the 2-tap post-detection filter, inserting
// a flush of FILT_LAT bubbles after each line and honouring downstream back-pressure.
module post_filter_scheduler
  import post_filter_pkg::*;
#(
  parameter int unsigned IMG_W    = IMG_W_DEF,
  parameter int unsigned IMG_H    = IMG_H_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned FILT_LAT = FILT_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              buf_ready,
  input  logic              abort,
  input  logic              out_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              filt_enb,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned COL_W = cnt_w(IMG_W);
  localparam int unsigned ROW_W = cnt_w(IMG_H);
  localparam int unsigned FLS_W = cnt_w(FILT_LAT + 1);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [FLS_W-1:0] FLS_LAST = FLS_W'(FILT_LAT - 1);

  logic [STATE_W-1:0] state, state_nxt;
  logic [COL_W-1:0]   col, col_nxt;
  logic [ROW_W-1:0]   row, row_nxt;
  logic [FLS_W-1:0]   flush_cnt, flush_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic               active_c;
  logic               advance_c;
  logic               pipe_din_c;
  logic               pipe_clr_c;

  // state and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      col       <= '0;
      row       <= '0;
      flush_cnt <= '0;
      rd_addr   <= '0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
      flush_cnt <= flush_nxt;
      rd_addr   <= addr_nxt;
    end
  end

  // next-state, counter updates and read/enable strobes
  always_comb begin
    state_nxt  = state;
    col_nxt    = col;
    row_nxt    = row;
    flush_nxt  = flush_cnt;
    addr_nxt   = rd_addr;
    pipe_clr_c = 1'b0;

    active_c   = (state == ST_RUN) || (state == ST_FLUSH);
    advance_c  = active_c && (!out_valid || out_ready);
    rd_en      = advance_c && (state == ST_RUN);
    filt_enb   = advance_c;
    // column 0 averages across the line boundary, so it never produces an output
    pipe_din_c = rd_en && (col != '0);

    case (state)
      ST_IDLE: begin
        if (start && buf_ready) begin
          state_nxt  = ST_RUN;
          col_nxt    = '0;
          row_nxt    = '0;
          flush_nxt  = '0;
          addr_nxt   = '0;
          pipe_clr_c = 1'b1;
        end
      end
      ST_RUN: begin
        if (rd_en) begin
          addr_nxt = rd_addr + ADDR_W'(1);
          if (col == COL_LAST) begin
            col_nxt   = '0;
            flush_nxt = '0;
            state_nxt = ST_FLUSH;
          end else begin
            col_nxt = col + COL_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (advance_c) begin
          if (flush_cnt == FLS_LAST) begin
            if (row == ROW_LAST) begin
              state_nxt = ST_DONE;
            end else begin
              row_nxt   = row + ROW_W'(1);
              state_nxt = ST_RUN;
            end
          end else begin
            flush_nxt = flush_cnt + FLS_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // abort overrides every line/frame transition and drops in-flight tags
    if (abort && active_c) begin
      state_nxt  = ST_IDLE;
      col_nxt    = col;
      row_nxt    = row;
      flush_nxt  = flush_cnt;
      addr_nxt   = rd_addr;
      pipe_clr_c = 1'b1;
    end
  end

  assign busy       = active_c;
  assign frame_done = (state == ST_DONE);

  valid_delay_line #(
    .DEPTH (FILT_LAT)
  ) u_valid_delay_line (
    .clk      (clk),
    .reset    (reset),
    .shift_en (advance_c),
    .din      (pipe_din_c),
    .clear    (pipe_clr_c),
    .dout     (out_valid)
  );

endmodule

// File: tb/tb_post_filter_scheduler.sv
// Bench for post_filter_scheduler: models the external filter as a tag pipeline and
// checks read order, emitted pixels, flush phases, stalls, abort and reset.
module tb_post_filter_scheduler;

  localparam int TW = 4;
  localparam int TH = 3;
  localparam int TL = 3;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          reset, start, buf_ready, abort, out_ready;
  logic          rd_en, filt_enb, out_valid, busy, frame_done;
  logic [AW-1:0] rd_addr;

  logic          start2, out_ready2, abort2;
  logic          rd_en2, filt_enb2, out_valid2, busy2, frame_done2;
  logic [AW-1:0] rd_addr2;

  int errors = 0;
  int checks = 0;

  int exp_rd[$];
  int exp_out[$];
  int runs[$];
  int fpipe[TL];
  int nreads, nouts, ndone, cur_run;
  bit pv_stall;
  logic [AW-1:0] pv_addr;

  always #5 clk = ~clk;

  post_filter_scheduler #(.IMG_W(TW), .IMG_H(TH), .ADDR_W(AW), .FILT_LAT(TL)) dut (
    .clk(clk), .reset(reset), .start(start), .buf_ready(buf_ready), .abort(abort),
    .out_ready(out_ready), .rd_en(rd_en), .rd_addr(rd_addr), .filt_enb(filt_enb),
    .out_valid(out_valid), .busy(busy), .frame_done(frame_done)
  );

  post_filter_scheduler #(.IMG_W(2), .IMG_H(1), .ADDR_W(AW), .FILT_LAT(TL)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .buf_ready(1'b1), .abort(abort2),
    .out_ready(out_ready2), .rd_en(rd_en2), .rd_addr(rd_addr2), .filt_enb(filt_enb2),
    .out_valid(out_valid2), .busy(busy2), .frame_done(frame_done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // expected frame: every address once in order; outputs are all pixels off column 0
  task automatic begin_frame();
    exp_rd.delete();
    exp_out.delete();
    runs.delete();
    for (int a = 0; a < TW * TH; a++) begin
      exp_rd.push_back(a);
      if (a % TW != 0) exp_out.push_back(a);
    end
    nreads = 0; nouts = 0; ndone = 0; cur_run = 0;
  endtask

  task automatic clear_model();
    for (int k = 0; k < TL; k++) fpipe[k] = -1;
    pv_stall = 1'b0;
    pv_addr  = '0;
  endtask

  // one clock: sample at negedge, update the filter model, return at posedge+1
  task automatic cyc();
    int e;
    int tag;
    @(negedge clk);
    if (rd_en && !abort) begin
      nreads++;
      if (exp_rd.size() != 0) e = exp_rd.pop_front(); else e = -1;
      chk("rd_addr_seq", 32'(rd_addr), 32'(e));
    end
    tag = fpipe[TL-1];
    if (out_valid && out_ready) begin
      nouts++;
      if (exp_out.size() != 0) e = exp_out.pop_front(); else e = -2;
      chk("out_pixel", 32'(tag), 32'(e));
    end
    if (out_valid && !out_ready) begin
      chk("stall_rd_en", 32'(rd_en), 32'd0);
      chk("stall_filt_enb", 32'(filt_enb), 32'd0);
    end
    if (pv_stall) begin
      chk("stall_hold_valid", 32'(out_valid), 32'd1);
      chk("stall_hold_addr", 32'(rd_addr), 32'(pv_addr));
    end
    if (frame_done) begin
      ndone++;
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_pipe_empty", 32'(out_valid), 32'd0);
    end
    if (filt_enb && !rd_en) cur_run++;
    else if ((rd_en || !busy) && cur_run != 0) begin
      runs.push_back(cur_run);
      cur_run = 0;
    end
    if (filt_enb) begin
      for (int k = TL - 1; k > 0; k--) fpipe[k] = fpipe[k-1];
      fpipe[0] = rd_en ? int'(rd_addr) : -1;
    end
    pv_stall = out_valid && !out_ready && !abort;
    pv_addr  = rd_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit rnd);
    bit got;
    int stall_left;
    bit stall_done;
    got = 1'b0;
    stall_left = 5;
    stall_done = !rnd;
    for (int i = 0; i < 400 && !got; i++) begin
      if (!stall_done && out_valid) begin
        out_ready = 1'b0;
        stall_left--;
        if (stall_left == 0) stall_done = 1'b1;
      end else if (rnd) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
      start = rnd && (i == 6 || i == 18);
      cyc();
      if (ndone != 0) got = 1'b1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("frame_done_seen", 32'(got), 32'd1);
    chk("reads_total", 32'(nreads), 32'(TW * TH));
    chk("outs_total", 32'(nouts), 32'(TH * (TW - 1)));
    chk("outs_missing", 32'(exp_out.size()), 32'd0);
    chk("flush_phases", 32'(runs.size()), 32'(TH));
    foreach (runs[k]) chk("flush_len", 32'(runs[k]), 32'(TL));
    repeat (3) begin
      cyc();
      chk("idle_after_frame", 32'(busy), 32'd0);
    end
    chk("done_once", 32'(ndone), 32'd1);
  endtask

  initial begin
    bit found;
    int cnt, nval;
    reset = 1'b1; start = 1'b0; buf_ready = 1'b0; abort = 1'b0; out_ready = 1'b1;
    start2 = 1'b0; out_ready2 = 1'b1; abort2 = 1'b0;
    clear_model();
    begin_frame();
    #3 reset = 1'b0;
    #1;
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_filt_enb", 32'(filt_enb), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // start without a buffered frame is ignored
    start = 1'b1; buf_ready = 1'b0;
    repeat (3) begin
      cyc();
      chk("nobuf_start_ignored", 32'(busy), 32'd0);
    end
    start = 1'b0;

    // full frame, no back-pressure; buf_ready drops right after acceptance
    begin_frame();
    buf_ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0; buf_ready = 1'b0;
    run_frame(1'b0);

    // random back-pressure, a forced 5-cycle stall, and starts while busy
    begin_frame();
    buf_ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    run_frame(1'b1);

    // abort while presenting address 6
    begin_frame();
    start = 1'b1;
    cyc();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (busy && rd_addr == AW'(6)) begin
        abort = 1'b1;
        found = 1'b1;
      end
      cyc();
    end
    abort = 1'b0;
    chk("abort_reached", 32'(found), 32'd1);
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_rd_en", 32'(rd_en), 32'd0);
    repeat (6) cyc();
    chk("abort_no_done", 32'(ndone), 32'd0);
    begin_frame();
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_frame(1'b0);

    // asynchronous reset in the middle of a flush
    begin_frame();
    start = 1'b1;
    cyc();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc();
      if (busy && filt_enb && !rd_en) found = 1'b1;
    end
    chk("flush_reached", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_rd_en", 32'(rd_en), 32'd0);
    chk("rst_mid_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_mid_filt_enb", 32'(filt_enb), 32'd0);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_frame_done", 32'(frame_done), 32'd0);
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    begin_frame();
    repeat (8) begin
      cyc();
      chk("post_rst_idle", 32'(busy), 32'd0);
    end
    chk("post_rst_no_done", 32'(ndone), 32'd0);

    // minimal 2x1 frame on the second instance
    start2 = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 start2 = 1'b0;
    cnt = 0; nval = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      cnt++;
      if (out_valid2 && out_ready2) nval++;
      if (frame_done2) found = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("w2_done_seen", 32'(found), 32'd1);
    chk("w2_done_within", 32'(cnt <= 6), 32'd1);
    chk("w2_outputs", 32'(nval), 32'd1);
    chk("w2_idle_after", 32'(busy2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/post_filter_scheduler.md
POST_FILTER_SCHEDULER -- requirements
Module: post_filter_scheduler

Interface
REQ-001 Parameter IMG_W, default 640, pixels per line (>=2).
REQ-002 Parameter IMG_H, default 480, lines per frame (>=1).
REQ-003 Parameter ADDR_W, default 19, line-buffer read-address width (2^ADDR_W >= IMG_W*IMG_H).
REQ-004 Parameter FILT_LAT, default 3, advance cycles from rd_en to that pixel's filtered result at the filter output.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  frame start request.
REQ-008 buf_ready  in  1  line buffer holds a complete frame.
REQ-009 abort  in  1  abandon current frame.
REQ-010 out_ready  in  1  downstream accepts filtered pixel.
REQ-011 rd_en  out  1  line-buffer read strobe; data valid at filter input next cycle.
REQ-012 rd_addr  out  ADDR_W  line-buffer read address.
REQ-013 filt_enb  out  1  enable to the 2-tap post-detection filter.
REQ-014 out_valid  out  1  filter output holds a valid pixel.
REQ-015 busy  out  1  frame in progress.
REQ-016 frame_done  out  1  one-cycle pulse at frame completion.

Function
REQ-017 States: IDLE, RUN, FLUSH, DONE; busy=1 in RUN and FLUSH.
REQ-018 IDLE->RUN when start=1 and buf_ready=1; col, row, rd_addr and valid pipeline cleared; start elsewhere, or with buf_ready=0, ignored.
REQ-019 advance = (RUN or FLUSH) and (out_valid=0 or out_ready=1); filt_enb = advance.
REQ-020 rd_en = advance and state=RUN; rd_addr increments by 1 per rd_en, linear row-major.
REQ-021 Valid pipeline: FILT_LAT-bit shift register, shifts only when advance=1; input bit = rd_en and col!=0; out_valid = last stage.
REQ-022 Column 0 of every line is tagged invalid (its average spans the previous line); each line yields IMG_W-1 outputs, each frame IMG_H*(IMG_W-1).
REQ-023 When out_valid=1 and out_ready=0: rd_en, filt_enb, counters and pipeline hold; out_valid stays 1.
REQ-024 RUN, read at col=IMG_W-1: col->0, state->FLUSH with flush counter cleared.
REQ-025 FLUSH: FILT_LAT advance cycles of bubbles (rd_en=0, input bit 0); then row=IMG_H-1 -> DONE, else row+1 -> RUN.
REQ-026 DONE: frame_done=1 one cycle, busy=0, ->IDLE; valid pipeline empty.
REQ-027 abort=1 in RUN/FLUSH: next state IDLE, valid pipeline cleared (out_valid=0 next cycle), no frame_done; abort has priority over start and row/line transitions.
REQ-028 buf_ready falling mid-frame does not affect the frame.
REQ-029 Counters: col ceil(log2 IMG_W) bits, row ceil(log2 IMG_H) bits, flush ceil(log2(FILT_LAT+1)) bits; no wrap beyond terminal values.

Reset
REQ-030 reset=0 asynchronously forces IDLE; rd_en, rd_addr, filt_enb, out_valid, busy, frame_done, counters and valid pipeline = 0.
REQ-031 Reset mid-frame discards the frame; after release, a new start is required.

Structure
REQ-032 Shared package post_filter_pkg holds the state encoding and FILT_LAT, IMG_W, IMG_H defaults.
REQ-033 Valid shift register is sub-module valid_delay_line (parameter DEPTH, inputs shift_en, din, clear).

Verification
REQ-034 IMG_W=4, IMG_H=3, out_ready=1, start with buf_ready=1 -> rd_addr 0..11 once each, 9 out_valid pulses, 3 FLUSH phases of 3 cycles, one frame_done, busy low after.
REQ-035 Same frame, out_ready=0 for 5 cycles while out_valid=1 -> rd_en, filt_enb 0 and rd_addr frozen for those cycles; still 9 outputs total, none lost or duplicated.
REQ-036 start while busy, and start with buf_ready=0 in IDLE -> ignored, rd_addr sequence unchanged, no extra frame_done.
REQ-037 abort at rd_addr=6 -> IDLE next cycle, out_valid=0, no frame_done; new start restarts at rd_addr=0.
REQ-038 reset=0 mid-FLUSH -> all outputs 0 immediately (asynchronous); after release stays IDLE until start.
REQ-039 IMG_W=2, IMG_H=1 -> 1 output, frame_done within 2+3+1 cycles of start acceptance.
